mips_kernel_ctrl: RTL and testbench



---
 rtl/mips_kernel_pkg.sv | 29 ++
 rtl/mips_kernel_ctrl_kernel_loader.sv | 69 ++++++
 rtl/mips_kernel_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mips_kernel_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_kernel_pkg.sv
// ---------------------------------------------------------------------------
// mips_kernel_pkg
// Shared types and constants for the MIPS kernel run-control sequencer:
//   - krnl_state_t : controller state (IDLE, RUN, DRAIN, DONE)
//   - ST_*         : completion status codes reported on o_krnl_status
//   - DEF_*        : default parameter values for the controller and loader
// ---------------------------------------------------------------------------
package mips_kernel_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } krnl_state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;
    localparam logic [1:0] ST_EMPTY   = 2'd3;

    localparam int DEF_INST_LEN     = 32;
    localparam int DEF_PC_W         = 32;
    localparam int DEF_IMEM_AW      = 8;
    localparam int DEF_CNT_W        = 32;
    localparam int DEF_MAX_CYCLES   = 100000;
    localparam int DEF_DRAIN_CYCLES = 3;

endpackage

// File: rtl/mips_kernel_ctrl_kernel_loader.sv
// ---------------------------------------------------------------------------
// kernel_loader
// Ready/valid beat-to-instruction-memory writer. Each accepted beat is
// written one cycle later at the pre-increment pointer value.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_idle             controller is in IDLE (loading and clear allowed)
//   i_clr              clear load pointer; wins over a same-cycle beat
//   i_valid, i_data    host instruction beat
//   o_ready            beat can be accepted (IDLE and not full)
//   o_accept           beat accepted this cycle (valid & ready & ~clr)
//   o_wr_en/addr/data  registered instruction-memory write port
//   o_count            instructions loaded (0 .. 2**IMEM_AW)
// ---------------------------------------------------------------------------
module kernel_loader
    import mips_kernel_pkg::*;
#(
    parameter int INST_LEN = DEF_INST_LEN,
    parameter int IMEM_AW  = DEF_IMEM_AW
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_idle,
    input  logic                i_clr,
    input  logic                i_valid,
    input  logic [INST_LEN-1:0] i_data,
    output logic                o_ready,
    output logic                o_accept,
    output logic                o_wr_en,
    output logic [IMEM_AW-1:0]  o_wr_addr,
    output logic [INST_LEN-1:0] o_wr_data,
    output logic [IMEM_AW:0]    o_count
);

    logic                r_wr_en;
    logic [IMEM_AW-1:0]  r_wr_addr;
    logic [INST_LEN-1:0] r_wr_data;
    logic [IMEM_AW:0]    r_count;
    logic                w_clr;

    assign w_clr    = i_idle & i_clr;
    // The count can only reach 2**IMEM_AW, so its MSB alone is the full flag.
    assign o_ready  = i_idle & ~r_count[IMEM_AW];
    assign o_accept = i_valid & o_ready & ~w_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_count   <= '0;
        end else begin
            r_wr_en <= o_accept;
            if (w_clr) begin
                r_count <= '0;
            end else if (o_accept) begin
                r_wr_addr <= r_count[IMEM_AW-1:0];
                r_wr_data <= i_data;
                r_count   <= r_count + (IMEM_AW+1)'(1);
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_count   = r_count;

endmodule

// File: rtl/mips_kernel_ctrl.sv
// ---------------------------------------------------------------------------
// mips_kernel_ctrl
// Run-control sequencer between the host and the MIPS pipeline top. Loads
// host instructions into instruction memory, holds the core in reset until
// a start command, runs it until the MEM-stage PC passes a run-time end PC
// (then drains the pipeline), a timeout expires, or the host aborts.
// Ports:
//   i_sys_clk, i_sys_rst_n          clock, asynchronous active-low reset
//   i_inst_valid/data, o_inst_ready host instruction stream
//   i_host_clr/start/abort          host commands
//   i_host_end_pc                   end PC, sampled at start
//   o_imem_wr_en/addr/data          instruction-memory write port
//   o_core_rst, o_core_en           core reset (active-high) and run enable
//   i_core_pc                       MEM-stage PC from the core
//   o_busy, o_krnl_done             not-IDLE flag, one-cycle completion pulse
//   o_krnl_status                   0 OK, 1 TIMEOUT, 2 ABORT, 3 EMPTY
//   o_cycle_count, o_inst_count     cycles spent running, instructions loaded
// ---------------------------------------------------------------------------
module mips_kernel_ctrl
    import mips_kernel_pkg::*;
#(
    parameter int INST_LEN     = DEF_INST_LEN,
    parameter int PC_W         = DEF_PC_W,
    parameter int IMEM_AW      = DEF_IMEM_AW,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_rst_n,
    input  logic                i_inst_valid,
    input  logic [INST_LEN-1:0] i_inst_data,
    output logic                o_inst_ready,
    input  logic                i_host_clr,
    input  logic                i_host_start,
    input  logic                i_host_abort,
    input  logic [PC_W-1:0]     i_host_end_pc,
    output logic                o_imem_wr_en,
    output logic [IMEM_AW-1:0]  o_imem_wr_addr,
    output logic [INST_LEN-1:0] o_imem_wr_data,
    output logic                o_core_rst,
    output logic                o_core_en,
    input  logic [PC_W-1:0]     i_core_pc,
    output logic                o_busy,
    output logic                o_krnl_done,
    output logic [1:0]          o_krnl_status,
    output logic [CNT_W-1:0]    o_cycle_count,
    output logic [IMEM_AW:0]    o_inst_count
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] LP_DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(MAX_CYCLES - 1);

    krnl_state_t        r_state;
    logic               r_core_rst;
    logic               r_core_en;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_status;
    logic [CNT_W-1:0]   r_cycle;
    logic [PC_W-1:0]    r_end_pc;
    logic [DRN_W-1:0]   r_drain;

    logic               w_accept;
    logic [IMEM_AW:0]   w_count;
    logic               w_has_prog;
    logic               w_timeout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    kernel_loader #(
        .INST_LEN (INST_LEN),
        .IMEM_AW  (IMEM_AW)
    ) u_loader (
        .i_clk     (i_sys_clk),
        .i_rst_n   (i_sys_rst_n),
        .i_idle    (~r_busy),
        .i_clr     (i_host_clr),
        .i_valid   (i_inst_valid),
        .i_data    (i_inst_data),
        .o_ready   (o_inst_ready),
        .o_accept  (w_accept),
        .o_wr_en   (o_imem_wr_en),
        .o_wr_addr (o_imem_wr_addr),
        .o_wr_data (o_imem_wr_data),
        .o_count   (w_count)
    );

    // A beat arriving with start counts; a clear arriving with start empties
    // the program, matching what the loader will hold after this edge.
    assign w_has_prog = w_accept | ((w_count != '0) & ~i_host_clr);
    assign w_timeout  = (MAX_CYCLES != 0) && (r_cycle == LP_TMO_LAST);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state    <= S_IDLE;
            r_core_rst <= 1'b1;
            r_core_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_status   <= ST_OK;
            r_cycle    <= '0;
            r_end_pc   <= '0;
            r_drain    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_host_start) begin
                        r_busy     <= 1'b1;
                        r_core_rst <= 1'b0;
                        r_cycle    <= '0;
                        if (w_has_prog) begin
                            r_state   <= S_RUN;
                            r_core_en <= 1'b1;
                            r_end_pc  <= i_host_end_pc;
                            r_status  <= ST_OK;
                        end else begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_status <= ST_EMPTY;
                        end
                    end
                end
                S_RUN: begin
                    r_cycle <= sat_inc(r_cycle);
                    // Priority: abort > end-PC > timeout.
                    if (i_host_abort) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_core_en <= 1'b0;
                        r_status  <= ST_ABORT;
                    end else if (i_core_pc > r_end_pc) begin
                        if (DRAIN_CYCLES == 0) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_core_en <= 1'b0;
                            r_status  <= ST_OK;
                        end else begin
                            r_state <= S_DRAIN;
                            r_drain <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_core_en <= 1'b0;
                        r_status  <= ST_TIMEOUT;
                    end
                end
                S_DRAIN: begin
                    r_cycle <= sat_inc(r_cycle);
                    r_drain <= r_drain + DRN_W'(1);
                    if (i_host_abort) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_core_en <= 1'b0;
                        r_status  <= ST_ABORT;
                    end else if (r_drain == LP_DRN_LAST) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_core_en <= 1'b0;
                        r_status  <= ST_OK;
                    end
                end
                S_DONE: begin
                    // Core stays frozen out of reset for one cycle so data
                    // memory is readable; reset reasserts back in IDLE.
                    r_state    <= S_IDLE;
                    r_core_rst <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_core_rst    = r_core_rst;
    assign o_core_en     = r_core_en;
    assign o_busy        = r_busy;
    assign o_krnl_done   = r_done;
    assign o_krnl_status = r_status;
    assign o_cycle_count = r_cycle;
    assign o_inst_count  = w_count;

endmodule

// File: tb/tb_mips_kernel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_kernel_ctrl
// Directed bench for mips_kernel_ctrl. dut_a uses a 256-deep memory and a
// 50-cycle timeout; dut_b shares the stimulus with a 4-deep memory for the
// full/overflow scenario.
// ---------------------------------------------------------------------------
module tb_mips_kernel_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_data = '0;
    logic        host_clr = 1'b0;
    logic        host_start = 1'b0;
    logic        host_abort = 1'b0;
    logic [31:0] end_pc = '0;
    logic [31:0] core_pc = '0;

    logic        a_ready, a_wr_en, a_core_rst, a_core_en, a_busy, a_done;
    logic [7:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [1:0]  a_status;
    logic [31:0] a_cycle;
    logic [8:0]  a_count;

    logic        b_ready, b_wr_en, b_core_rst, b_core_en, b_busy, b_done;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [1:0]  b_status;
    logic [31:0] b_cycle;
    logic [2:0]  b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_kernel_ctrl #(.IMEM_AW(8), .MAX_CYCLES(50), .DRAIN_CYCLES(3)) dut_a (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n),
        .i_inst_valid(inst_valid), .i_inst_data(inst_data), .o_inst_ready(a_ready),
        .i_host_clr(host_clr), .i_host_start(host_start), .i_host_abort(host_abort),
        .i_host_end_pc(end_pc),
        .o_imem_wr_en(a_wr_en), .o_imem_wr_addr(a_wr_addr), .o_imem_wr_data(a_wr_data),
        .o_core_rst(a_core_rst), .o_core_en(a_core_en), .i_core_pc(core_pc),
        .o_busy(a_busy), .o_krnl_done(a_done), .o_krnl_status(a_status),
        .o_cycle_count(a_cycle), .o_inst_count(a_count)
    );

    mips_kernel_ctrl #(.IMEM_AW(2), .MAX_CYCLES(50), .DRAIN_CYCLES(3)) dut_b (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n),
        .i_inst_valid(inst_valid), .i_inst_data(inst_data), .o_inst_ready(b_ready),
        .i_host_clr(host_clr), .i_host_start(host_start), .i_host_abort(host_abort),
        .i_host_end_pc(end_pc),
        .o_imem_wr_en(b_wr_en), .o_imem_wr_addr(b_wr_addr), .o_imem_wr_data(b_wr_data),
        .o_core_rst(b_core_rst), .o_core_en(b_core_en), .i_core_pc(core_pc),
        .o_busy(b_busy), .o_krnl_done(b_done), .o_krnl_status(b_status),
        .o_cycle_count(b_cycle), .o_inst_count(b_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %b want 1", a_core_rst); end
        checks++; if (a_core_en !== 1'b0) begin errors++; $display("FAIL rst_core_en: got %b want 0", a_core_en); end
        checks++; if (a_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", a_wr_en); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", a_done); end
        checks++; if (a_status !== 2'd0) begin errors++; $display("FAIL rst_status: got %0d want 0", a_status); end
        checks++; if (a_cycle !== 32'd0) begin errors++; $display("FAIL rst_cycle: got %0d want 0", a_cycle); end
        checks++; if (a_count !== 9'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", a_count); end
        checks++; if (a_wr_addr !== 8'd0 || a_wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_port: got %0h/%0h want 0/0", a_wr_addr, a_wr_data); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", a_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load4();
        for (int i = 0; i < 4; i++) begin
            inst_valid = 1'b1;
            inst_data  = 32'hA000_0000 + i;
            checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL load_ready[%0d]: got %b want 1", i, a_ready); end
            tick();
            checks++; if (a_wr_en !== 1'b1) begin errors++; $display("FAIL load_wr_en[%0d]: got %b want 1", i, a_wr_en); end
            checks++; if (a_wr_addr !== 8'(i)) begin errors++; $display("FAIL load_addr[%0d]: got %0d want %0d", i, a_wr_addr, i); end
            checks++; if (a_wr_data !== 32'hA000_0000 + i) begin errors++; $display("FAIL load_data[%0d]: got %0h want %0h", i, a_wr_data, 32'hA000_0000 + i); end
            checks++; if (a_count !== 9'(i + 1)) begin errors++; $display("FAIL load_count[%0d]: got %0d want %0d", i, a_count, i + 1); end
        end
        inst_valid = 1'b0;
        tick();
        checks++; if (a_wr_en !== 1'b0) begin errors++; $display("FAIL load_idle_wr_en: got %b want 0", a_wr_en); end
        checks++; if (a_count !== 9'd4) begin errors++; $display("FAIL load_final_count: got %0d want 4", a_count); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL load_final_ready: got %b want 1", a_ready); end
    endtask

    task automatic test_overflow();
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            inst_valid = 1'b1;
            inst_data  = 32'hB0 + i;
            checks++; if (b_ready !== (i < 4)) begin errors++; $display("FAIL ovf_ready[%0d]: got %b want %b", i, b_ready, (i < 4)); end
            tick();
            checks++; if (b_wr_en !== (i < 4)) begin errors++; $display("FAIL ovf_wr_en[%0d]: got %b want %b", i, b_wr_en, (i < 4)); end
            checks++; if (b_count !== 3'((i < 4) ? i + 1 : 4)) begin errors++; $display("FAIL ovf_count[%0d]: got %0d want %0d", i, b_count, (i < 4) ? i + 1 : 4); end
        end
        inst_valid = 1'b0;
        tick();
        checks++; if (b_wr_addr !== 2'd3 || b_wr_data !== 32'hB3) begin errors++; $display("FAIL ovf_last_write: got %0d/%0h want 3/b3", b_wr_addr, b_wr_data); end
        checks++; if (b_count !== 3'd4) begin errors++; $display("FAIL ovf_final_count: got %0d want 4", b_count); end
    endtask

    task automatic test_end_pc();
        end_pc = 32'd16; core_pc = 32'd0; host_start = 1'b1;
        tick();
        host_start = 1'b0;
        checks++; if (a_core_rst !== 1'b0 || a_core_en !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL endpc_run_entry: got rst=%b en=%b busy=%b want 0/1/1", a_core_rst, a_core_en, a_busy); end
        checks++; if (a_cycle !== 32'd0) begin errors++; $display("FAIL endpc_cycle0: got %0d want 0", a_cycle); end
        repeat (19) tick();
        checks++; if (a_cycle !== 32'd19) begin errors++; $display("FAIL endpc_cycle19: got %0d want 19", a_cycle); end
        core_pc = 32'd17;
        tick();
        core_pc = 32'd0;
        checks++; if (a_core_en !== 1'b1 || a_done !== 1'b0 || a_cycle !== 32'd20) begin errors++; $display("FAIL endpc_drain1: got en=%b done=%b cyc=%0d want 1/0/20", a_core_en, a_done, a_cycle); end
        repeat (2) tick();
        checks++; if (a_core_en !== 1'b1 || a_done !== 1'b0 || a_cycle !== 32'd22) begin errors++; $display("FAIL endpc_drain3: got en=%b done=%b cyc=%0d want 1/0/22", a_core_en, a_done, a_cycle); end
        tick();
        checks++; if (a_done !== 1'b1 || a_status !== 2'd0) begin errors++; $display("FAIL endpc_done: got done=%b st=%0d want 1/0", a_done, a_status); end
        checks++; if (a_cycle !== 32'd23) begin errors++; $display("FAIL endpc_cycles: got %0d want 23", a_cycle); end
        checks++; if (a_core_en !== 1'b0 || a_core_rst !== 1'b0) begin errors++; $display("FAIL endpc_freeze: got en=%b rst=%b want 0/0", a_core_en, a_core_rst); end
        tick();
        checks++; if (a_done !== 1'b0 || a_core_rst !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL endpc_idle: got done=%b rst=%b busy=%b want 0/1/0", a_done, a_core_rst, a_busy); end
        checks++; if (a_cycle !== 32'd23 || a_status !== 2'd0) begin errors++; $display("FAIL endpc_hold: got cyc=%0d st=%0d want 23/0", a_cycle, a_status); end
    endtask

    task automatic test_timeout();
        int n;
        end_pc = 32'hFFFF_FFFF; core_pc = 32'd0; host_start = 1'b1;
        tick();
        host_start = 1'b0;
        n = 0;
        while (a_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n != 50) begin errors++; $display("FAIL tmo_latency: got %0d want 50", n); end
        checks++; if (a_status !== 2'd1) begin errors++; $display("FAIL tmo_status: got %0d want 1", a_status); end
        checks++; if (a_cycle !== 32'd50) begin errors++; $display("FAIL tmo_cycles: got %0d want 50", a_cycle); end
        tick();
    endtask

    task automatic test_abort_vs_endpc();
        end_pc = 32'd16; core_pc = 32'd0; host_start = 1'b1;
        tick();
        host_start = 1'b0;
        repeat (3) tick();
        core_pc = 32'd100; host_abort = 1'b1;
        tick();
        host_abort = 1'b0; core_pc = 32'd0;
        checks++; if (a_done !== 1'b1 || a_status !== 2'd2) begin errors++; $display("FAIL abort_prio: got done=%b st=%0d want 1/2", a_done, a_status); end
        tick();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b want 0", a_busy); end
    endtask

    task automatic test_empty();
        host_clr = 1'b1;
        tick();
        host_clr = 1'b0;
        checks++; if (a_count !== 9'd0) begin errors++; $display("FAIL empty_clr: got %0d want 0", a_count); end
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        checks++; if (a_done !== 1'b1 || a_status !== 2'd3 || a_core_en !== 1'b0) begin errors++; $display("FAIL empty_done: got done=%b st=%0d en=%b want 1/3/0", a_done, a_status, a_core_en); end
        tick();
        checks++; if (a_done !== 1'b0 || a_busy !== 1'b0 || a_status !== 2'd3) begin errors++; $display("FAIL empty_idle: got done=%b busy=%b st=%0d want 0/0/3", a_done, a_busy, a_status); end
    endtask

    task automatic test_start_ignored();
        inst_valid = 1'b1; inst_data = 32'hC0; host_start = 1'b1;
        end_pc = 32'd8; core_pc = 32'd0;
        tick();
        inst_valid = 1'b0; host_start = 1'b0;
        checks++; if (a_core_en !== 1'b1 || a_core_rst !== 1'b0) begin errors++; $display("FAIL bts_run: got en=%b rst=%b want 1/0", a_core_en, a_core_rst); end
        checks++; if (a_wr_en !== 1'b1 || a_wr_addr !== 8'd0 || a_count !== 9'd1) begin errors++; $display("FAIL bts_write: got we=%b addr=%0d cnt=%0d want 1/0/1", a_wr_en, a_wr_addr, a_count); end
        repeat (3) tick();
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        checks++; if (a_cycle !== 32'd4 || a_core_en !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL restart_ignored: got cyc=%0d en=%b busy=%b want 4/1/1", a_cycle, a_core_en, a_busy); end
        host_abort = 1'b1;
        tick();
        host_abort = 1'b0;
        checks++; if (a_done !== 1'b1 || a_status !== 2'd2) begin errors++; $display("FAIL run_abort: got done=%b st=%0d want 1/2", a_done, a_status); end
        tick();
    endtask

    task automatic test_async_reset();
        int n;
        end_pc = 32'd8; core_pc = 32'd0; host_start = 1'b1;
        tick();
        host_start = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_core_rst !== 1'b1 || a_core_en !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL arst_ctrl: got rst=%b en=%b busy=%b want 1/0/0", a_core_rst, a_core_en, a_busy); end
        checks++; if (a_cycle !== 32'd0 || a_count !== 9'd0 || a_done !== 1'b0) begin errors++; $display("FAIL arst_regs: got cyc=%0d cnt=%0d done=%b want 0/0/0", a_cycle, a_count, a_done); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        inst_valid = 1'b1; inst_data = 32'hD0;
        tick();
        inst_data = 32'hD1;
        tick();
        inst_valid = 1'b0;
        checks++; if (a_count !== 9'd2) begin errors++; $display("FAIL arst_reload: got %0d want 2", a_count); end
        end_pc = 32'd16; host_start = 1'b1;
        tick();
        host_start = 1'b0;
        repeat (2) tick();
        core_pc = 32'd20;
        tick();
        core_pc = 32'd0;
        n = 0;
        while (a_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (a_done !== 1'b1 || a_status !== 2'd0) begin errors++; $display("FAIL arst_rerun_done: got done=%b st=%0d want 1/0", a_done, a_status); end
        checks++; if (a_cycle !== 32'd6) begin errors++; $display("FAIL arst_rerun_cycles: got %0d want 6", a_cycle); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load4();
        test_overflow();
        test_end_pc();
        test_timeout();
        test_abort_vs_endpc();
        test_empty();
        test_start_ignored();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
